// File: rtl/max_finder_pkg.sv
// -----------------------------------------------------------------------------
// max_finder_pkg
// Shared types and default sizing for the max_finder_ctrl slice.
//   state_t       : controller states (IDLE, FETCH, CMP, DONE)
//   MF_NUM_BITS   : default data word width
//   MF_NUM_WORDS  : default number of words per search (>= 2)
// -----------------------------------------------------------------------------
package max_finder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MF_NUM_BITS  = 4;
  localparam int MF_NUM_WORDS = 4;

endpackage

// File: rtl/max_finder_ctrl_greater_than.sv
// -----------------------------------------------------------------------------
// greater_than
// Unsigned magnitude comparator shared by the max finder.
// Ports:
//   a  in  W  left operand
//   b  in  W  right operand
//   o  out 1  1 when a > b (unsigned)
// -----------------------------------------------------------------------------
module greater_than #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         o
);

  assign o = (a > b);

endmodule

// File: rtl/max_finder_ctrl.sv
// -----------------------------------------------------------------------------
// max_finder_ctrl
// Finds the largest of NUM_WORDS unsigned words received over a valid/ready
// stream, using a single shared greater_than comparator, and reports the value
// and its 0-based arrival index with a one-cycle done pulse.
//
// Ports:
//   clk       in   1         system clock, rising edge
//   rst       in   1         asynchronous, active-high reset
//   start     in   1         begin a search (sampled only in IDLE)
//   in_valid  in   1         source presents a word on in_data
//   in_data   in   NUM_BITS  unsigned word
//   in_ready  out  1         word accepted this cycle (decoded from state)
//   busy      out  1         search in progress (decoded from state)
//   done      out  1         one-cycle pulse, max_val/max_idx valid
//   max_val   out  NUM_BITS  largest word of the last search
//   max_idx   out  IDX_BITS  arrival index of max_val
//
// Build option:
//   MAX_FINDER_CTRL_TIE_LAST_EN  when defined, equal words also update the
//                                result so the last occurrence of the maximum
//                                wins; otherwise the first occurrence wins.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; previous result held on max_val/max_idx
// FETCH | in_ready high, waiting for in_valid to capture the next word
// CMP   | compare captured word against running max, advance counter
// DONE  | search complete; done pulse is registered out of this state
// -----------------------------------------------------------------------------
module max_finder_ctrl
  import max_finder_pkg::*;
#(
  parameter  int NUM_BITS  = MF_NUM_BITS,
  parameter  int NUM_WORDS = MF_NUM_WORDS,
  localparam int IDX_BITS  = $clog2(NUM_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] max_val,
  output logic [IDX_BITS-1:0] max_idx
);

  state_t state_q, state_d;

  logic [IDX_BITS-1:0] count_q,   count_d;
  logic [NUM_BITS-1:0] data_q,    data_d;
  logic [NUM_BITS-1:0] max_val_q, max_val_d;
  logic [IDX_BITS-1:0] max_idx_q, max_idx_d;
  logic                done_q,    done_d;

  logic gt;
  logic last_word;
  logic take_word;

  greater_than #(
    .W (NUM_BITS)
  ) u_gt (
    .a (data_q),
    .b (max_val_q),
    .o (gt)
  );

  assign last_word = (count_q == IDX_BITS'(NUM_WORDS - 1));

  // The first word of a search always seeds the running max, regardless of
  // what the previous search left in max_val_q.
`ifdef MAX_FINDER_CTRL_TIE_LAST_EN
  assign take_word = (count_q == '0) || gt || (data_q == max_val_q);
`else
  assign take_word = (count_q == '0) || gt;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = FETCH;
      FETCH:   if (in_valid) state_d = CMP;
      CMP:     state_d = last_word ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE:    begin in_ready = 1'b0; busy = 1'b0; end
      FETCH:   begin in_ready = 1'b1; busy = 1'b1; end
      CMP:     begin in_ready = 1'b0; busy = 1'b1; end
      DONE:    begin in_ready = 1'b0; busy = 1'b1; end
      default: begin in_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    data_d    = data_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    // done is registered from the DONE state, so it rises on the edge that
    // leaves DONE and is seen during the following IDLE cycle.
    done_d    = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start) count_d = '0;
      end
      FETCH: begin
        if (in_valid) data_d = in_data;
      end
      CMP: begin
        if (take_word) begin
          max_val_d = data_q;
          max_idx_d = count_q;
        end
        // Terminal compare exits to DONE, so the counter never wraps.
        if (!last_word) count_d = count_q + IDX_BITS'(1);
      end
      DONE: begin
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      data_q    <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      data_q    <= data_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      done_q    <= done_d;
    end
  end

  assign done    = done_q;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: tb/tb_max_finder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_max_finder_ctrl
// Directed testbench for max_finder_ctrl with NUM_BITS=4, NUM_WORDS=4.
// Cycle numbers count rising edges after the edge that samples start (edge 0).
// -----------------------------------------------------------------------------
module tb_max_finder_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] max_val;
  logic [1:0] max_idx;

  int n_vec;
  int n_err;

  max_finder_ctrl #(
    .NUM_BITS  (4),
    .NUM_WORDS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_val  (max_val),
    .max_idx  (max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one search. Inputs change and outputs are observed on the falling
  // edge. gap_idx/gap_len drop in_valid for gap_len FETCH cycles before word
  // gap_idx; start_again_cyc pulses start at that cycle; stop_cyc bounds the run.
  task automatic do_search(
    input  logic [3:0] w0, input logic [3:0] w1,
    input  logic [3:0] w2, input logic [3:0] w3,
    input  int gap_idx, input int gap_len,
    input  int start_again_cyc, input int stop_cyc,
    output int done_cyc, output int done_cnt,
    output int busy_first, output int busy_at_done, output int busy_late,
    output int early_max, output int gap_ready_low,
    output int res_val, output int res_idx
  );
    logic [3:0] w[4];
    int c, widx, gap_rem;
    logic rdy;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    done_cyc = -1; done_cnt = 0; busy_first = -1; busy_at_done = -1;
    busy_late = -1; early_max = -1; gap_ready_low = 0;
    res_val = -1; res_idx = -1;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    c = 0; widx = 0; gap_rem = gap_len;
    while (c < stop_cyc) begin
      @(negedge clk);
      if (c == 0) busy_first = int'(busy);
      if (c == 1) early_max = int'(max_val);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = int'(busy);
          res_val      = int'(max_val);
          res_idx      = int'(max_idx);
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_late = int'(busy);
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      start = (c == start_again_cyc);
      if (widx == gap_idx && gap_rem > 0 && (in_ready || gap_rem < gap_len)) begin
        if (!in_ready) gap_ready_low++;
        in_valid = 1'b0;
        in_data  = 4'hE;
        gap_rem--;
      end else if (widx < 4) begin
        in_valid = 1'b1;
        in_data  = w[widx];
      end else begin
        in_valid = 1'b0;
        in_data  = 4'h0;
      end
      rdy = in_ready;
      @(posedge clk);
      c++;
      if (in_valid && rdy) widx++;
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (max_val !== 4'd0) begin n_err++; $display("FAIL reset_max_val: got %0d want 0", max_val); end
    n_vec++; if (max_idx !== 2'd0) begin n_err++; $display("FAIL reset_max_idx: got %0d want 0", max_idx); end
  endtask

  task automatic test_basic;
    int dc, dn, bf, bd, bl, em, gr, rv, ri;
    do_search(4'd3, 4'd9, 4'd2, 4'd7, -1, 0, -1, 40, dc, dn, bf, bd, bl, em, gr, rv, ri);
    n_vec++; if (dc !== 9) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 9", dc); end
    n_vec++; if (rv !== 9) begin n_err++; $display("FAIL basic_max_val: got %0d want 9", rv); end
    n_vec++; if (ri !== 1) begin n_err++; $display("FAIL basic_max_idx: got %0d want 1", ri); end
    n_vec++; if (bf !== 1) begin n_err++; $display("FAIL basic_busy_after_start: got %0d want 1", bf); end
    n_vec++; if (bd !== 0) begin n_err++; $display("FAIL basic_busy_at_done: got %0d want 0", bd); end
    n_vec++; if (bl !== 0) begin n_err++; $display("FAIL basic_busy_after_done: got %0d want 0", bl); end
    n_vec++; if (dn !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dn); end
  endtask

  task automatic test_ties;
    int dc, dn, bf, bd, bl, em, gr, rv, ri;
    int exp_idx;
`ifdef MAX_FINDER_CTRL_TIE_LAST_EN
    exp_idx = 3;
`else
    exp_idx = 0;
`endif
    do_search(4'd5, 4'd5, 4'd1, 4'd5, -1, 0, -1, 40, dc, dn, bf, bd, bl, em, gr, rv, ri);
    n_vec++; if (em !== 9) begin n_err++; $display("FAIL ties_prev_result_held: got %0d want 9", em); end
    n_vec++; if (rv !== 5) begin n_err++; $display("FAIL ties_max_val: got %0d want 5", rv); end
    n_vec++; if (ri !== exp_idx) begin n_err++; $display("FAIL ties_max_idx: got %0d want %0d", ri, exp_idx); end
    n_vec++; if (dc !== 9) begin n_err++; $display("FAIL ties_done_cycle: got %0d want 9", dc); end
  endtask

  task automatic test_zeros;
    int dc, dn, bf, bd, bl, em, gr, rv, ri;
    do_search(4'd0, 4'd0, 4'd0, 4'd0, -1, 0, -1, 40, dc, dn, bf, bd, bl, em, gr, rv, ri);
    n_vec++; if (rv !== 0) begin n_err++; $display("FAIL zeros_max_val: got %0d want 0", rv); end
    n_vec++; if (ri !== 0) begin n_err++; $display("FAIL zeros_max_idx: got %0d want 0", ri); end
    n_vec++; if (dn !== 1) begin n_err++; $display("FAIL zeros_done_count: got %0d want 1", dn); end
  endtask

  task automatic test_valid_gap;
    int dc, dn, bf, bd, bl, em, gr, rv, ri;
    do_search(4'd1, 4'd2, 4'd15, 4'd4, 2, 3, -1, 40, dc, dn, bf, bd, bl, em, gr, rv, ri);
    n_vec++; if (gr !== 0) begin n_err++; $display("FAIL gap_in_ready_low_cycles: got %0d want 0", gr); end
    n_vec++; if (dc !== 12) begin n_err++; $display("FAIL gap_done_cycle: got %0d want 12", dc); end
    n_vec++; if (rv !== 15) begin n_err++; $display("FAIL gap_max_val: got %0d want 15", rv); end
    n_vec++; if (ri !== 2) begin n_err++; $display("FAIL gap_max_idx: got %0d want 2", ri); end
  endtask

  task automatic test_start_while_busy;
    int dc, dn, bf, bd, bl, em, gr, rv, ri;
    do_search(4'd3, 4'd9, 4'd2, 4'd7, -1, 0, 4, 40, dc, dn, bf, bd, bl, em, gr, rv, ri);
    n_vec++; if (dn !== 1) begin n_err++; $display("FAIL restart_done_count: got %0d want 1", dn); end
    n_vec++; if (dc !== 9) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 9", dc); end
    n_vec++; if (rv !== 9) begin n_err++; $display("FAIL restart_max_val: got %0d want 9", rv); end
    n_vec++; if (ri !== 1) begin n_err++; $display("FAIL restart_max_idx: got %0d want 1", ri); end
    n_vec++; if (bl !== 0) begin n_err++; $display("FAIL restart_busy_after_done: got %0d want 0", bl); end
  endtask

  task automatic test_reset_abort;
    int dc, dn, bf, bd, bl, em, gr, rv, ri;
    // Stop after edge 6: word 2 has been compared, running max is 9.
    do_search(4'd3, 4'd9, 4'd2, 4'd7, -1, 0, -1, 6, dc, dn, bf, bd, bl, em, gr, rv, ri);
    rst = 1'b1;
    #1;
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
    n_vec++; if (max_val !== 4'd0) begin n_err++; $display("FAIL abort_max_val: got %0d want 0", max_val); end
    n_vec++; if (max_idx !== 2'd0) begin n_err++; $display("FAIL abort_max_idx: got %0d want 0", max_idx); end
    @(negedge clk);
    rst = 1'b0;
    do_search(4'd8, 4'd1, 4'd1, 4'd1, -1, 0, -1, 40, dc, dn, bf, bd, bl, em, gr, rv, ri);
    n_vec++; if (dc !== 9) begin n_err++; $display("FAIL after_abort_done_cycle: got %0d want 9", dc); end
    n_vec++; if (rv !== 8) begin n_err++; $display("FAIL after_abort_max_val: got %0d want 8", rv); end
    n_vec++; if (ri !== 0) begin n_err++; $display("FAIL after_abort_max_idx: got %0d want 0", ri); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_ties();
    test_zeros();
    test_valid_gap();
    test_start_while_busy();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
